// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types, encodings and decode helper for the multicycle control FSM
package ctrl_pkg;

  // One state per datapath step; all 16 codes of the 4-bit field are used
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JTGT      = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  // ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    AOP_ADD = 2'd0,
    AOP_SUB = 2'd1,
    AOP_R   = 2'd2,
    AOP_I   = 2'd3
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;

  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Per-state control word held in the output register
  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_write;
    logic       ru_wr;
    logic [2:0] imm_src;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    alu_op_t    alu_op;
    logic [1:0] result_src;
  } ctl_t;

  // Dispatch target chosen in DECODE; unknown opcodes trap
  function automatic state_t decode_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: decode_op = S_MEM_ADDR;
      OP_R:              decode_op = S_EXEC_R;
      OP_I:              decode_op = S_EXEC_I;
      OP_BRANCH:         decode_op = S_BRANCH;
      OP_JAL:            decode_op = S_JAL;
      OP_JALR:           decode_op = S_JALR;
      OP_LUI:            decode_op = S_LUI;
      OP_AUIPC:          decode_op = S_AUIPC;
      default:           decode_op = S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALU operation class and funct fields to the ALU control code
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctrl
);

  // funct7b5 only distinguishes SRAI from SRLI among immediates; elsewhere it is immediate data
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      AOP_ADD: alu_ctrl = ALU_ADD;
      AOP_SUB: alu_ctrl = ALU_SUB;
      AOP_R:   alu_ctrl = {funct7b5, funct3};
      AOP_I:   alu_ctrl = {(funct3 == 3'b101) & funct7b5, funct3};
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM sequencing the shared datapath
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit RESET_TRAP_CLR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       br_cond,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       ru_wr,
  output logic [2:0] imm_src,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [3:0] alu_ctrl,
  output logic [1:0] result_src,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  state_t     state;
  ctl_t       ctl_q;
  logic       illegal_q;
  logic [3:0] dec_ctrl;

  function automatic state_t next_state(input state_t s, input logic [6:0] op,
                                        input logic iready, input logic dready);
    case (s)
      S_FETCH:     next_state = iready ? S_DECODE : S_FETCH;
      S_DECODE:    next_state = decode_op(op);
      S_MEM_ADDR:  next_state = (op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next_state = dready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next_state = dready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: next_state = S_ALU_WB;
      S_JAL, S_JALR: next_state = S_JTGT;
      S_TRAP:      next_state = S_TRAP;
      default:     next_state = S_FETCH;
    endcase
  endfunction

  // Control word for a state; ready/branch-qualified strobes are added outside the register
  function automatic ctl_t ctl_for(input state_t s, input logic [6:0] op);
    ctl_t c;
    c = '0;
    c.alu_op = AOP_ADD;
    case (s)
      S_FETCH: begin
        c.imem_req = 1'b1; c.alu_a_sel = A_PC; c.alu_b_sel = B_FOUR; c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.imm_src = IMM_B; c.alu_a_sel = A_OLDPC; c.alu_b_sel = B_IMM;
      end
      S_MEM_ADDR: begin
        c.imm_src = (op == OP_STORE) ? IMM_S : IMM_I; c.alu_a_sel = A_RS1; c.alu_b_sel = B_IMM;
      end
      S_MEM_READ:  c.dmem_req = 1'b1;
      S_MEM_WB: begin
        c.ru_wr = 1'b1; c.result_src = RES_DATA;
      end
      S_MEM_WRITE: begin
        c.dmem_req = 1'b1; c.dmem_we = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_a_sel = A_RS1; c.alu_b_sel = B_RS2; c.alu_op = AOP_R;
      end
      S_EXEC_I: begin
        c.imm_src = IMM_I; c.alu_a_sel = A_RS1; c.alu_b_sel = B_IMM; c.alu_op = AOP_I;
      end
      S_ALU_WB: begin
        c.ru_wr = 1'b1; c.result_src = RES_ALUOUT;
      end
      S_BRANCH: begin
        c.alu_a_sel = A_RS1; c.alu_b_sel = B_RS2; c.alu_op = AOP_SUB; c.result_src = RES_ALUOUT;
      end
      S_JAL, S_JALR: begin
        c.alu_a_sel = A_OLDPC; c.alu_b_sel = B_FOUR; c.result_src = RES_ALU; c.ru_wr = 1'b1;
      end
      S_JTGT: begin
        c.imm_src   = (op == OP_JALR) ? IMM_I : IMM_J;
        c.alu_a_sel = (op == OP_JALR) ? A_RS1 : A_OLDPC;
        c.alu_b_sel = B_IMM; c.result_src = RES_ALU; c.pc_write = 1'b1;
      end
      S_LUI: begin
        c.imm_src = IMM_U; c.alu_a_sel = A_ZERO; c.alu_b_sel = B_IMM;
      end
      S_AUIPC: begin
        c.imm_src = IMM_U; c.alu_a_sel = A_OLDPC; c.alu_b_sel = B_IMM;
      end
      default: c = '0;
    endcase
    ctl_for = c;
  endfunction

  // State, registered control word and sticky trap flag advance together
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      ctl_q     <= ctl_for(S_FETCH, opcode);
      illegal_q <= 1'b0;
    end else begin
      state <= next_state(state, opcode, imem_ready, dmem_ready);
      ctl_q <= ctl_for(next_state(state, opcode, imem_ready, dmem_ready), opcode);
      if (next_state(state, opcode, imem_ready, dmem_ready) == S_TRAP)
        illegal_q <= 1'b1;
      else if (!RESET_TRAP_CLR && state != S_FETCH &&
               next_state(state, opcode, imem_ready, dmem_ready) == S_FETCH)
        illegal_q <= 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op   (ctl_q.alu_op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_ctrl (dec_ctrl)
  );

  // Reset silences every output in the same cycle so an aborted instruction writes nothing
  assign imem_req      = ctl_q.imem_req & ~rst;
  assign dmem_req      = ctl_q.dmem_req & ~rst;
  assign dmem_we       = ctl_q.dmem_we & ~rst;
  assign ir_write      = (state == S_FETCH) & imem_ready & ~rst;
  assign pc_write      = (ctl_q.pc_write | ((state == S_FETCH) & imem_ready) |
                          ((state == S_BRANCH) & br_cond)) & ~rst;
  assign ru_wr         = ctl_q.ru_wr & ~rst;
  assign imm_src       = rst ? 3'b000 : ctl_q.imm_src;
  assign alu_a_sel     = rst ? 2'b00 : ctl_q.alu_a_sel;
  assign alu_b_sel     = rst ? 2'b00 : ctl_q.alu_b_sel;
  assign alu_ctrl      = rst ? 4'b0000 : dec_ctrl;
  assign result_src    = rst ? 2'b00 : ctl_q.result_src;
  assign illegal_instr = illegal_q & ~rst;
  assign state_dbg     = rst ? 4'b0000 : state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for the multicycle control FSM
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       br_cond = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, ru_wr, illegal_instr;
  logic [2:0] imm_src;
  logic [1:0] alu_a_sel, alu_b_sel, result_src;
  logic [3:0] alu_ctrl, state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .br_cond(br_cond), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write),
    .pc_write(pc_write), .ru_wr(ru_wr), .imm_src(imm_src), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl), .result_src(result_src),
    .illegal_instr(illegal_instr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Expected word: {state, imem_req,dmem_req,dmem_we,ir_write,pc_write,ru_wr,illegal, imm, a, b, alu, res}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] FWT  = 7'b1000000;
  localparam logic [6:0] FGO  = 7'b1001100;
  localparam logic [6:0] DRD  = 7'b0100000;
  localparam logic [6:0] DWR  = 7'b0110000;
  localparam logic [6:0] PCW  = 7'b0000100;
  localparam logic [6:0] RUW  = 7'b0000010;
  localparam logic [6:0] ILL  = 7'b0000001;

  localparam logic [23:0] F_WAIT = {4'd0, FWT, 3'b000, 2'b00, 2'b10, 4'b0000, 2'b10};
  localparam logic [23:0] F_GO   = {4'd0, FGO, 3'b000, 2'b00, 2'b10, 4'b0000, 2'b10};
  localparam logic [23:0] DEC    = {4'd1, NONE, 3'b101, 2'b01, 2'b01, 4'b0000, 2'b00};
  localparam logic [23:0] WB     = {4'd8, RUW, 3'b000, 2'b00, 2'b00, 4'b0000, 2'b00};
  localparam logic [23:0] LD_ADR = {4'd2, NONE, 3'b000, 2'b10, 2'b01, 4'b0000, 2'b00};
  localparam logic [23:0] LD_RD  = {4'd3, DRD, 3'b000, 2'b00, 2'b00, 4'b0000, 2'b00};

  typedef struct {
    logic        rst;
    logic        ir;
    logic        dr;
    logic        bc;
    logic [23:0] exp;
  } ent_t;

  ent_t sb[$];

  task automatic push(input logic r, input logic i, input logic d, input logic b,
                      input logic [23:0] e);
    ent_t x;
    x.rst = r; x.ir = i; x.dr = d; x.bc = b; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic set_instr(input logic [31:0] w);
    opcode   = w[6:0];
    funct3   = w[14:12];
    funct7b5 = w[30];
  endtask

  // Drive one cycle of inputs and sample all outputs 1 ns after the falling edge
  task automatic step(input ent_t e, output logic [23:0] act);
    @(negedge clk);
    rst = e.rst; imem_ready = e.ir; dmem_ready = e.dr; br_cond = e.bc;
    #1;
    act = {state_dbg, imem_req, dmem_req, dmem_we, ir_write, pc_write, ru_wr, illegal_instr,
           imm_src, alu_a_sel, alu_b_sel, alu_ctrl, result_src};
  endtask

  task automatic test_reset;
    ent_t e; logic [23:0] act; int k = 0;
    push(1, 0, 0, 0, 24'h0);
    push(1, 1, 1, 1, 24'h0);
    push(0, 0, 0, 0, F_WAIT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e, act); n_cmp++;
      if (act !== e.exp) begin n_fail++; $display("FAIL reset c%0d: got %h want %h", k, act, e.exp); end
      k++;
    end
  endtask

  task automatic test_exec_r(input logic [31:0] w, input logic [3:0] alu);
    ent_t e; logic [23:0] act; int k = 0;
    set_instr(w);
    push(0, 1, 0, 0, F_GO);
    push(0, 1, 0, 0, DEC);
    push(0, 1, 0, 0, {4'd6, NONE, 3'b000, 2'b10, 2'b00, alu, 2'b00});
    push(0, 1, 0, 0, WB);
    push(0, 0, 0, 0, F_WAIT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e, act); n_cmp++;
      if (act !== e.exp) begin n_fail++; $display("FAIL exec_r %h c%0d: got %h want %h", w, k, act, e.exp); end
      k++;
    end
  endtask

  task automatic test_exec_i(input logic [31:0] w, input logic [3:0] alu);
    ent_t e; logic [23:0] act; int k = 0;
    set_instr(w);
    push(0, 1, 0, 0, F_GO);
    push(0, 0, 0, 0, DEC);
    push(0, 0, 0, 0, {4'd7, NONE, 3'b000, 2'b10, 2'b01, alu, 2'b00});
    push(0, 0, 0, 0, WB);
    push(0, 0, 0, 0, F_WAIT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e, act); n_cmp++;
      if (act !== e.exp) begin n_fail++; $display("FAIL exec_i %h c%0d: got %h want %h", w, k, act, e.exp); end
      k++;
    end
  endtask

  task automatic test_load;
    ent_t e; logic [23:0] act; int k = 0;
    set_instr(32'h0080A283);
    push(0, 1, 0, 0, F_GO);
    push(0, 1, 1, 0, DEC);
    push(0, 1, 1, 0, LD_ADR);
    push(0, 0, 0, 0, LD_RD);
    push(0, 0, 0, 0, LD_RD);
    push(0, 0, 0, 0, LD_RD);
    push(0, 0, 1, 0, LD_RD);
    push(0, 0, 0, 0, {4'd4, RUW, 3'b000, 2'b00, 2'b00, 4'b0000, 2'b01});
    push(0, 0, 0, 0, F_WAIT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e, act); n_cmp++;
      if (act !== e.exp) begin n_fail++; $display("FAIL load c%0d: got %h want %h", k, act, e.exp); end
      k++;
    end
  endtask

  task automatic test_store;
    ent_t e; logic [23:0] act; int k = 0;
    set_instr(32'h0020A223);
    push(0, 0, 1, 0, F_WAIT);
    push(0, 0, 1, 0, F_WAIT);
    push(0, 1, 0, 0, F_GO);
    push(0, 0, 0, 0, DEC);
    push(0, 0, 0, 0, {4'd2, NONE, 3'b001, 2'b10, 2'b01, 4'b0000, 2'b00});
    push(0, 0, 0, 0, {4'd5, DWR, 3'b000, 2'b00, 2'b00, 4'b0000, 2'b00});
    push(0, 0, 1, 0, {4'd5, DWR, 3'b000, 2'b00, 2'b00, 4'b0000, 2'b00});
    push(0, 0, 0, 0, F_WAIT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e, act); n_cmp++;
      if (act !== e.exp) begin n_fail++; $display("FAIL store c%0d: got %h want %h", k, act, e.exp); end
      k++;
    end
  endtask

  task automatic test_branch(input logic bc);
    ent_t e; logic [23:0] act; int k = 0;
    set_instr(32'h00208463);
    push(0, 1, 0, 0, F_GO);
    push(0, 0, 0, ~bc, DEC);
    push(0, 0, 0, bc, {4'd9, bc ? PCW : NONE, 3'b000, 2'b10, 2'b00, 4'b1000, 2'b00});
    push(0, 0, 0, bc, F_WAIT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e, act); n_cmp++;
      if (act !== e.exp) begin n_fail++; $display("FAIL branch bc=%0d c%0d: got %h want %h", bc, k, act, e.exp); end
      k++;
    end
  endtask

  task automatic test_jump(input logic [31:0] w, input logic is_jalr);
    ent_t e; logic [23:0] act; int k = 0;
    set_instr(w);
    push(0, 1, 0, 0, F_GO);
    push(0, 0, 0, 0, DEC);
    push(0, 0, 0, 0, {is_jalr ? 4'd11 : 4'd10, RUW, 3'b000, 2'b01, 2'b10, 4'b0000, 2'b10});
    push(0, 0, 0, 0, {4'd12, PCW, is_jalr ? 3'b000 : 3'b110, is_jalr ? 2'b10 : 2'b01,
                      2'b01, 4'b0000, 2'b10});
    push(0, 0, 0, 0, F_WAIT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e, act); n_cmp++;
      if (act !== e.exp) begin n_fail++; $display("FAIL jump %h c%0d: got %h want %h", w, k, act, e.exp); end
      k++;
    end
  endtask

  task automatic test_upper(input logic [31:0] w, input logic is_lui);
    ent_t e; logic [23:0] act; int k = 0;
    set_instr(w);
    push(0, 1, 0, 0, F_GO);
    push(0, 0, 0, 0, DEC);
    push(0, 0, 0, 0, {is_lui ? 4'd13 : 4'd14, NONE, 3'b010, is_lui ? 2'b11 : 2'b01,
                      2'b01, 4'b0000, 2'b00});
    push(0, 0, 0, 0, WB);
    push(0, 0, 0, 0, F_WAIT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e, act); n_cmp++;
      if (act !== e.exp) begin n_fail++; $display("FAIL upper %h c%0d: got %h want %h", w, k, act, e.exp); end
      k++;
    end
  endtask

  task automatic test_trap;
    ent_t e; logic [23:0] act; int k = 0;
    set_instr(32'h0000007F);
    push(0, 1, 0, 0, F_GO);
    push(0, 0, 0, 0, DEC);
    for (int i = 0; i < 20; i++)
      push(0, i[0], ~i[0], i[1], {4'd15, ILL, 3'b000, 2'b00, 2'b00, 4'b0000, 2'b00});
    push(1, 0, 0, 0, 24'h0);
    push(0, 0, 0, 0, F_WAIT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e, act); n_cmp++;
      if (act !== e.exp) begin n_fail++; $display("FAIL trap c%0d: got %h want %h", k, act, e.exp); end
      k++;
    end
  endtask

  task automatic test_reset_mid_read;
    ent_t e; logic [23:0] act; int k = 0;
    set_instr(32'h0080A283);
    push(0, 1, 0, 0, F_GO);
    push(0, 0, 0, 0, DEC);
    push(0, 0, 0, 0, LD_ADR);
    push(0, 0, 0, 0, LD_RD);
    push(1, 0, 1, 0, 24'h0);
    push(0, 0, 0, 0, F_WAIT);
    push(0, 0, 0, 0, F_WAIT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step(e, act); n_cmp++;
      if (act !== e.exp) begin n_fail++; $display("FAIL reset_mid_read c%0d: got %h want %h", k, act, e.exp); end
      k++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_exec_r(32'h002081B3, 4'b0000);
    test_exec_r(32'h402081B3, 4'b1000);
    test_exec_i(32'h4030D093, 4'b1101);
    test_exec_i(32'hC0000093, 4'b0000);
    test_load;
    test_store;
    test_branch(1'b1);
    test_branch(1'b0);
    test_jump(32'h008000EF, 1'b0);
    test_jump(32'h000080E7, 1'b1);
    test_upper(32'h123450B7, 1'b1);
    test_upper(32'h00001097, 1'b0);
    test_reset_mid_read;
    test_trap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM for the RV32I core. It sequences the shared datapath (instruction register, register unit, immediate generator, ALU, PC, memories) over several cycles per instruction. It drives the immediate-generator select, ALU operand and operation selects, write strobes, and memory request handshakes. It replaces the single-cycle combinational decoder when the core is built in multicycle mode.

Parameters:
- RESET_TRAP_CLR, 1, 1 = `illegal_instr` is cleared only by `rst`; 0 = it is also cleared on re-entry to FETCH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- br_cond  in  1  branch unit result for the current funct3 (1 = taken)
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write enable, valid with `dmem_req`
- ir_write  out  1  load IR and old-PC register
- pc_write  out  1  load PC from the result mux
- ru_wr  out  1  register unit write
- imm_src  out  3  immediate select: I=000, S=001, U=010, B=101, J=110
- alu_a_sel  out  2  00 PC, 01 oldPC, 10 rs1
- alu_b_sel  out  2  00 rs2, 01 imm, 10 const 4
- alu_ctrl  out  4  ALU operation: ADD 0000, SUB 1000, funct3-derived codes otherwise
- result_src  out  2  00 ALUOut register, 01 data read, 10 ALU direct
- illegal_instr  out  1  sticky trap flag
- state_dbg  out  4  current state encoding

Behaviour:
- While `rst`=1:
  - State becomes FETCH on the next edge.
  - All outputs are forced to 0, including `imem_req`.
  - `illegal_instr` clears.
- A reset asserted mid-instruction aborts it.
  - Outputs go to 0 in that same cycle.
  - No partial write may occur: `pc_write`, `ru_wr` and `dmem_req` are all 0.
- FETCH:
  - `imem_req`=1, `alu_a`=PC, `alu_b`=4, ADD, `result_src`=10.
  - Holds while `imem_ready`=0.
  - On `imem_ready`=1: `ir_write`=1 and `pc_write`=1 in the same cycle, then go to DECODE.
  - Minimum fetch latency is 1 cycle.
- DECODE:
  - `imm_src`=B, `alu_a`=oldPC, `alu_b`=imm, ADD (branch target into ALUOut).
  - Next state by opcode:
    - 0000011 or 0100011 → MEM_ADDR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - any other opcode → TRAP
- MEM_ADDR: `imm_src`=I for loads, S for stores; `alu_a`=rs1, `alu_b`=imm, ADD. Next state is MEM_READ for loads, MEM_WRITE for stores.
- MEM_READ: `dmem_req`=1, `dmem_we`=0; holds until `dmem_ready`, then goes to MEM_WB.
- MEM_WB: `result_src`=01, `ru_wr`=1, then FETCH.
- MEM_WRITE: `dmem_req`=1, `dmem_we`=1; holds until `dmem_ready`, then goes to FETCH.
- EXEC_R: `alu_a`=rs1, `alu_b`=rs2. `alu_ctrl`={`funct7b5`, `funct3`}. Next state ALU_WB.
- EXEC_I: `imm_src`=I, `alu_b`=imm. `alu_ctrl`={`funct7b5` only when `funct3`=101 (else 0), `funct3`}. Next state ALU_WB.
- ALU_WB: `result_src`=00, `ru_wr`=1, then FETCH.
- BRANCH:
  - `alu_a`=rs1, `alu_b`=rs2, SUB.
  - `result_src`=00, `pc_write`=`br_cond`, then FETCH.
  - Not-taken costs the same 3 cycles as taken.
- JAL:
  - `alu_a`=oldPC, `alu_b`=4, ADD, `result_src`=10, `ru_wr`=1 (rd ← oldPC+4). Next state JTGT.
  - JTGT: `imm_src`=J, `alu_a`=oldPC, `alu_b`=imm, `result_src`=10, `pc_write`=1, then FETCH.
- JALR: same as JAL, except JTGT uses `imm_src`=I and `alu_a`=rs1. The datapath clears bit 0 of the target.
- LUI: `imm_src`=U, `alu_a`=PC with PC zeroed by the datapath on `alu_a_sel`=11, `alu_b`=imm. Goes to ALU_WB.
- AUIPC: `imm_src`=U, `alu_a`=oldPC, `alu_b`=imm, ADD. Goes to ALU_WB.
- TRAP:
  - `illegal_instr`=1.
  - All strobes are 0.
  - Stays in TRAP until reset.
- `ready` inputs are ignored outside their wait states.
- Writes are never issued on the same edge as a state entry without the qualifying `ready` where one is required.

Decomposition:
- Package `ctrl_pkg` holds:
  - state enum (4-bit)
  - opcode constants
  - imm_src constants (I/S/U/B/J)
  - ALU control codes
  - mux select constants
- Sub-module `alu_decoder` (combinational): inputs alu_op class plus `funct3` and `funct7b5`, output `alu_ctrl`.

Test Plan:
- `add x3,x1,x2` (0x002081B3), `imem_ready` held at 1 → FETCH→DECODE→EXEC_R→ALU_WB. `ru_wr` pulses in cycle 4, `alu_ctrl`=0000, next FETCH in cycle 5.
- `lw x5,8(x1)` (0x0080A283), `dmem_ready` delayed 3 cycles → `dmem_req` high for 4 cycles with `dmem_we`=0, `imm_src`=000 in MEM_ADDR, `ru_wr` exactly once with `result_src`=01.
- `sw x2,4(x1)` (0x0020A223) → `imm_src`=001, `dmem_we`=1, `ru_wr` never asserted.
- `beq` (0x00208463) with `br_cond`=1, then again with `br_cond`=0 → `pc_write` in the BRANCH cycle only when taken. `imm_src`=101 in DECODE for both.
- Opcode 0x7F → TRAP; `illegal_instr`=1 holds for 20 cycles; `rst` pulse returns to FETCH with `illegal_instr`=0.
- `rst` asserted in MEM_READ with `dmem_ready`=1 → `ru_wr` stays 0, state returns to FETCH, no write.
